// File: rtl/uart_tx_buffered_if.sv
// Transmit-side bus for uart_tx_buffered: byte write handshake, serial line and status.
// Handshake: a byte transfers on a rising clk edge where start && ready are both high;
// start with ready low is ignored, and data only needs to be stable in that cycle.
interface uart_tx_buffered_if;
  logic       start;
  logic [7:0] data;
  logic       ready;
  logic       busy;
  logic       tx;
  logic [2:0] dbg_state;

  modport master (
    output start, data,
    input  ready, busy, tx, dbg_state
  );

  modport slave (
    input  start, data,
    output ready, busy, tx, dbg_state
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter with a small write FIFO and gapless back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_buffered #(
  parameter int BAUDRATE = 1302,
  parameter int FIFO_AW  = 2
) (
  input logic            clk,
  input logic            rst,
  uart_tx_buffered_if.slave bus
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL      = (FIFO_AW + 1)'(DEPTH);
  localparam logic [15:0]        BAUD_LAST = 16'(BAUDRATE - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [15:0]        baud_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               tx_q;
  logic [7:0]         head;
  logic               bit_end;
  logic               push;
  logic               pop;
`ifdef UART_TX_PARITY_EN
  logic               par_bit;
`endif

  assign head    = mem[rd_ptr];
  assign bit_end = (baud_cnt == BAUD_LAST);
  assign push    = bus.start && bus.ready;
  // The head leaves the FIFO on the same edge the start bit is driven.
  assign pop     = (count != '0) && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

  assign bus.ready     = (count != FULL);
  assign bus.busy      = (state != S_IDLE) || (count != '0);
  assign bus.tx        = tx_q;
  assign bus.dbg_state = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx_q     <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx_q     <= 1'b1;
          if (pop) begin
            shreg <= head;
`ifdef UART_TX_PARITY_EN
            par_bit <= ^head;
`endif
            tx_q  <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= shreg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q  <= par_bit;
              state <= S_PARITY;
`else
              tx_q  <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= shreg >> 1;
              tx_q    <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx_q     <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            // Chain straight into the next start bit when more bytes are queued.
            if (pop) begin
              shreg <= head;
`ifdef UART_TX_PARITY_EN
              par_bit <= ^head;
`endif
              tx_q  <= 1'b0;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          tx_q     <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed scenarios plus random pushes,
// compared cycle by cycle against a frame-level line model.
module tb_uart_tx_buffered;
  localparam int BAUD  = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BAUD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_tx_buffered_if bus();

  uart_tx_buffered #(.BAUDRATE(BAUD), .FIFO_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: queued bytes and the line levels still to be driven for the current frame.
  logic [7:0] exp_q[$];
  logic       wave[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_fall_cyc = -1;
  int busy_fall_cyc = -1;
  int push_edge = 0;
  int refused = 0;
  logic prev_tx = 1'b1;
  logic prev_busy = 1'b0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input logic [7:0] b);
    repeat (BAUD) wave.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (BAUD) wave.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    repeat (BAUD) wave.push_back(^b);
`endif
    repeat (BAUD) wave.push_back(1'b1);
  endtask

  // One clock: drive inputs at negedge, advance the model at posedge, check #1 later.
  task automatic step(input logic s, input logic [7:0] d, input logic r);
    logic acc;
    logic in_frame;
    logic tx_exp;
    @(negedge clk);
    rst       = r;
    bus.start = s;
    bus.data  = d;
    #1;
    acc = !r && s && (exp_q.size() < DEPTH);
    if (s && !r) begin
      check1("ready_at_push", bus.ready, exp_q.size() < DEPTH);
      if (!bus.ready) refused++;
    end
    @(posedge clk);
    cyc++;
    in_frame = 1'b0;
    tx_exp   = 1'b1;
    if (r) begin
      exp_q.delete();
      wave.delete();
    end else begin
      if (wave.size() == 0 && exp_q.size() != 0) load_frame(exp_q.pop_front());
      in_frame = (wave.size() != 0);
      if (in_frame) tx_exp = wave.pop_front();
      if (acc) exp_q.push_back(d);
    end
    #1;
    check1("tx", bus.tx, tx_exp);
    check1("busy", bus.busy, in_frame || (exp_q.size() != 0));
    check1("ready", bus.ready, exp_q.size() < DEPTH);
    if (prev_tx && !bus.tx && tx_fall_cyc < 0) tx_fall_cyc = cyc;
    if (prev_busy && !bus.busy && busy_fall_cyc < 0) busy_fall_cyc = cyc;
    prev_tx   = bus.tx;
    prev_busy = bus.busy;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] burst [6];
    bus.start = 1'b0;
    bus.data  = 8'h00;
    burst = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

    // Reset, then a long idle stretch.
    repeat (3) step(1'b0, 8'h00, 1'b1);
    idle(50);

    // Single byte: latency, waveform and busy span.
    tx_fall_cyc = -1;
    busy_fall_cyc = -1;
    step(1'b1, 8'h55, 1'b0);
    push_edge = cyc;
    idle(FRAME + 5);
    checki("tx_fall_latency", tx_fall_cyc - push_edge, 1);
    checki("busy_span", busy_fall_cyc - tx_fall_cyc, FRAME);

    // Burst of six: the sixth finds the FIFO full.
    refused = 0;
    for (int i = 0; i < 6; i++) step(1'b1, burst[i], 1'b0);
    checki("burst_refused", refused, 1);
    idle(5 * FRAME + 10);

    // Hammer pushes while full; refused bytes must not appear on the line.
    refused = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    checki("full_refused", refused, 5);
    idle(5 * FRAME + 10);

    // Reset mid-DATA of 0xA5 with more bytes queued, then a clean 0x3C.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    idle(3 * BAUD);
    step(1'b0, 8'h00, 1'b1);
    idle(FRAME);
    tx_fall_cyc = -1;
    busy_fall_cyc = -1;
    step(1'b1, 8'h3C, 1'b0);
    push_edge = cyc;
    idle(FRAME + 5);
    checki("post_reset_latency", tx_fall_cyc - push_edge, 1);
    checki("post_reset_span", busy_fall_cyc - tx_fall_cyc, FRAME);

    // Pointer wrap: twelve single pushes, one frame apart.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'(i), 1'b0);
      idle(FRAME + 1);
    end

    // Random pushes against the model.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) == 0, 8'($urandom), 1'b0);
    idle((DEPTH + 2) * FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
